seq_input_checker: RTL and testbench
====================================

Name: seq_input_checker

Overview:
- Sequence memory and player-input judge for the tile memory game.
- Generates and stores the random tile sequence for a round, and serves tiles by index to the graphics control FSM for flashing.
- Captures player key presses, compares each one against the stored sequence, and returns player_input/check to the graphics FSM.
- Sits between the board keys and the graphics control FSM.

Parameters:
- MAX_LEN, 16, sequence memory depth (entries).
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- gen_start  in  1  one-cycle pulse: generate a new sequence of length len
- len  in  5  round length; 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN
- gen_done  out  1  one-cycle pulse: generation finished
- rd_index  in  4  sequence index to read
- rd_tile  out  2  tile at rd_index, registered, 1-cycle latency
- player_en  in  1  player turn active; presses are captured only while high
- keys  in  4  raw active-low tile keys; keys[i] selects tile i
- check_en  in  1  one-cycle pulse: consume the captured press
- player_input  out  1  press captured, awaiting check_en
- check  out  1  captured press matches seq[step]; valid while player_input=1
- pressed_tile  out  2  tile of the captured press
- step  out  5  index of the next expected entry
- round_done  out  1  sticky: all len entries matched
- fail  out  1  sticky: mismatch occurred

Behaviour:
- Reset (async, resetn=0), state IDLE:
  - all outputs 0
  - step=0
  - LFSR=LFSR_SEED
  - key synchronizer flops = 4'hF
  - memory contents undefined
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle regardless of state.
  - New tile value = lfsr[1:0].
- Keys:
  - 2-flop synchronizer, then inverted: ks = ~sync.
  - single = exactly one bit of ks set.
  - none = ks==0.
- FSM states: IDLE, GEN, WAIT_PRESS, HOLD, RELEASE, DONE, FAIL.
  - IDLE: wait for gen_start.
  - GEN:
    - On entry, wr_ptr=0 and L = clamped len.
    - Each cycle writes mem[wr_ptr]=lfsr[1:0] and increments wr_ptr.
    - After writing entry L-1, pulses gen_done for 1 cycle, clears step/round_done/fail, and goes to RELEASE.
    - Occupies exactly L cycles; gen_done rises in the cycle after the last write.
  - RELEASE: when none holds, go to WAIT_PRESS. This also blocks keys held over from the previous press.
  - WAIT_PRESS:
    - If player_en && single: latch pressed_tile = index of the set bit, latch check = (pressed_tile == mem[step]), go to HOLD.
    - Multi-key or no-key cycles are ignored.
  - HOLD:
    - player_input=1; check and pressed_tile held stable.
    - On check_en, match and step==L-1: set round_done, go to DONE.
    - On check_en, match and step<L-1: step++, go to RELEASE.
    - On check_en, mismatch: set fail, go to FAIL.
    - player_input clears in the cycle after check_en.
  - DONE and FAIL: sticky; leave only on gen_start.
- gen_start has priority in every state, including mid-GEN and HOLD: it restarts GEN at wr_ptr=0 and clears player_input, check, round_done, fail and step.
- check_en outside HOLD is ignored.
- Press latency: a key low on cycle t is captured into HOLD at t+3 (two sync cycles plus one state update).
- rd_tile: synchronous read of mem[rd_index], independent of state. Reading index ≥ L returns stale contents and is legal.
- Memory write and read to the same address in the same cycle return the old data.
- Deasserting player_en does not abandon HOLD: the captured press stays pending until check_en.

Decomposition:
- Shared package holds:
  - state encodings
  - TILE_W=2
  - LFSR tap constant
  - default LFSR_SEED
- One natural sub-module: key_sync_edge (4-bit 2-flop synchronizer plus one-hot/none decode).

Test Plan:
- Reset, then gen_start with len=4: gen_done pulses 4 cycles after gen_start (GEN occupies exactly 4 cycles); rd_index 0..3 return values in 0..3; all other outputs stay 0 with step=0.
- Correct round, len=3: for i=0..2 read rd_index=i, press keys with ~(1<<tile), release, pulse check_en. Expect player_input=1 and check=1 each time, step advancing 0→1→2, then round_done=1.
- Wrong press at step 0 (tile = mem[0]^1): check=0, and after check_en fail=1 and round_done=0.
- keys=4'b1100 (two keys) in WAIT_PRESS: no capture, player_input stays 0; releasing to 4'b1110 captures tile 0 at t+3.
- Holding a key through check_en: no second capture until all keys read 4'hF; player_en=0 blocks capture.
- Edge cases:
  - len=0 behaves as 1; len=20 clamps to 16, so gen_done comes 16 cycles after gen_start.
  - gen_start mid-GEN restarts generation.
  - gen_start in HOLD or FAIL clears all flags.
  - resetn low mid-GEN returns to IDLE at once, with all outputs 0.

Source files
------------

// File: rtl/seq_input_checker_pkg.sv
// Shared definitions for the tile memory game sequence checker.
// Holds the FSM state encoding, tile/length widths, LFSR polynomial and seed,
// and the LFSR step function.
package seq_input_checker_pkg;
  localparam int TILE_W = 2;
  localparam int LEN_W  = 5;
  localparam int LFSR_W = 8;

  // x^8+x^6+x^5+x^4+1, shift-left Fibonacci form: feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_WAIT_PRESS, S_HOLD, S_RELEASE, S_DONE, S_FAIL
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/seq_input_checker_if.sv
// Bus between the sequence checker (slave) and its controller (master):
// generation control, sequence read port, key/press handshake and status.
interface seq_input_checker_if;
  logic       gen_start;
  logic [4:0] len;
  logic       gen_done;
  logic [3:0] rd_index;
  logic [1:0] rd_tile;
  logic       player_en;
  logic [3:0] keys;
  logic       check_en;
  logic       player_input;
  logic       check;
  logic [1:0] pressed_tile;
  logic [4:0] step;
  logic       round_done;
  logic       fail;

  modport master (
    output gen_start, len, rd_index, player_en, keys, check_en,
    input  gen_done, rd_tile, player_input, check, pressed_tile, step,
           round_done, fail
  );
  modport slave (
    input  gen_start, len, rd_index, player_en, keys, check_en,
    output gen_done, rd_tile, player_input, check, pressed_tile, step,
           round_done, fail
  );
endinterface

// File: rtl/seq_input_checker_key_sync_edge.sv
// key_sync_edge: two-flop synchronizer for active-low keys, then decode of
// the pressed set into "exactly one" / "none" and the index of the set bit.
// Ports: clock, resetn (async low), i_keys (raw active-low),
//        o_single, o_none, o_idx (valid when o_single).
module key_sync_edge #(
  parameter int NUM_KEYS = 4,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] i_keys,
  output logic                o_single,
  output logic                o_none,
  output logic [IDX_W-1:0]    o_idx
);
  logic [NUM_KEYS-1:0] r_sync1, r_sync2;
  logic [NUM_KEYS-1:0] w_ks, w_ks_m1;

  // Idle level of active-low keys is all ones.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_keys;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ks     = ~r_sync2;
  assign w_ks_m1  = w_ks - NUM_KEYS'(1);
  assign o_none   = (w_ks == '0);
  // Power-of-two test: clearing the lowest set bit leaves nothing.
  assign o_single = !o_none && ((w_ks & w_ks_m1) == '0);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (w_ks[i]) o_idx = IDX_W'(i);
  end
endmodule

// File: rtl/seq_input_checker.sv
// seq_input_checker: generates a random tile sequence into a small memory,
// serves tiles by index, and judges player key presses against it.
// Ports: clock, resetn (async low), bus (seq_input_checker_if.slave):
//   gen_start/len -> gen_done, rd_index -> rd_tile (1-cycle),
//   player_en/keys/check_en -> player_input/check/pressed_tile/step,
//   round_done/fail sticky status.
module seq_input_checker import seq_input_checker_pkg::*; #(
  parameter int                MAX_LEN   = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input logic                 clock,
  input logic                 resetn,
  seq_input_checker_if.slave  bus
);
  localparam int AW = $clog2(MAX_LEN);

  state_t              r_state;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [AW-1:0]       r_wr_ptr;
  logic [LEN_W-1:0]    r_len;
  logic [TILE_W-1:0]   r_mem [MAX_LEN];
  logic [TILE_W-1:0]   r_rd_tile, r_ptile;
  logic [LEN_W-1:0]    r_step;
  logic                r_gen_done, r_pinput, r_check, r_done, r_fail;

  logic [LEN_W-1:0]    w_len_c;
  logic [TILE_W-1:0]   w_exp, w_idx;
  logic                w_single, w_none, w_we;

  key_sync_edge #(.NUM_KEYS(4)) u_keys (
    .clock(clock), .resetn(resetn), .i_keys(bus.keys),
    .o_single(w_single), .o_none(w_none), .o_idx(w_idx)
  );

  always_comb begin
    w_len_c = bus.len;
    if (bus.len == '0)                   w_len_c = LEN_W'(1);
    else if (int'(bus.len) > MAX_LEN)    w_len_c = LEN_W'(MAX_LEN);
  end

  assign w_exp = r_mem[r_step[AW-1:0]];
  // A restart in the same cycle abandons the pending write.
  assign w_we  = (r_state == S_GEN) && !bus.gen_start;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= lfsr_next(r_lfsr);
  end

  // Memory is not reset; a read of the address being written returns old data.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[r_wr_ptr] <= r_lfsr[TILE_W-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_rd_tile <= '0;
    else         r_rd_tile <= r_mem[bus.rd_index];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_len      <= '0;
      r_gen_done <= 1'b0;
      r_pinput   <= 1'b0;
      r_check    <= 1'b0;
      r_ptile    <= '0;
      r_step     <= '0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_gen_done <= 1'b0;
      if (bus.gen_start) begin
        r_state  <= S_GEN;
        r_wr_ptr <= '0;
        r_len    <= w_len_c;
        r_pinput <= 1'b0;
        r_check  <= 1'b0;
        r_step   <= '0;
        r_done   <= 1'b0;
        r_fail   <= 1'b0;
      end else begin
        case (r_state)
          S_GEN: begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (LEN_W'(r_wr_ptr) == r_len - LEN_W'(1)) begin
              r_gen_done <= 1'b1;
              r_step     <= '0;
              r_done     <= 1'b0;
              r_fail     <= 1'b0;
              r_state    <= S_RELEASE;
            end
          end
          // Wait for all keys up so a held key is never captured twice.
          S_RELEASE: if (w_none) r_state <= S_WAIT_PRESS;
          S_WAIT_PRESS: begin
            if (bus.player_en && w_single) begin
              r_ptile  <= w_idx;
              r_check  <= (w_idx == w_exp);
              r_pinput <= 1'b1;
              r_state  <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (bus.check_en) begin
              r_pinput <= 1'b0;
              if (!r_check) begin
                r_fail  <= 1'b1;
                r_state <= S_FAIL;
              end else if (r_step == r_len - LEN_W'(1)) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_step  <= r_step + LEN_W'(1);
                r_state <= S_RELEASE;
              end
            end
          end
          default: ;  // IDLE, DONE, FAIL hold until gen_start
        endcase
      end
    end
  end

  assign bus.gen_done     = r_gen_done;
  assign bus.rd_tile      = r_rd_tile;
  assign bus.player_input = r_pinput;
  assign bus.check        = r_check;
  assign bus.pressed_tile = r_ptile;
  assign bus.step         = r_step;
  assign bus.round_done   = r_done;
  assign bus.fail         = r_fail;
endmodule

// File: tb/tb_seq_input_checker.sv
// Self-checking bench for seq_input_checker: a behavioural model (sequence
// array, key delay line, round flags) is advanced each negedge from the
// inputs about to be sampled; a compare process checks every output each
// cycle. Directed scenarios add literal expectations, then random play.
module tb_seq_input_checker;
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_input_checker_if bus();
  seq_input_checker #(.MAX_LEN(16), .LFSR_SEED(8'hA5)) dut (
    .clock(clock), .resetn(resetn), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_lfsr;
  logic [1:0] m_mem [16];
  bit         m_val [16];
  logic [3:0] m_kq0, m_kq1;
  int         m_L, m_gen_left, m_wr, m_step;
  bit         m_active, m_armed, m_pend, m_done, m_fail, m_check, m_gdone;
  logic [1:0] m_ptile, m_rd;
  bit         m_rd_val;

  task automatic m_reset();
    m_lfsr = 8'hA5; m_kq0 = 4'hF; m_kq1 = 4'hF;
    m_L = 1; m_gen_left = 0; m_wr = 0; m_step = 0;
    m_active = 0; m_armed = 0; m_pend = 0; m_done = 0; m_fail = 0;
    m_check = 0; m_gdone = 0; m_ptile = 0; m_rd = 0; m_rd_val = 1;
    for (int i = 0; i < 16; i++) m_val[i] = 0;
  endtask

  // Outputs after the coming posedge, given the inputs now on the bus.
  task automatic m_advance();
    logic [3:0] ks;
    int l;
    ks = ~m_kq1;
    m_rd = m_mem[bus.rd_index];
    m_rd_val = m_val[bus.rd_index];
    m_gdone = 0;
    if (bus.gen_start) begin
      l = int'(bus.len);
      m_L = (l == 0) ? 1 : (l > 16 ? 16 : l);
      m_gen_left = m_L; m_wr = 0; m_active = 0; m_pend = 0;
      m_check = 0; m_done = 0; m_fail = 0; m_step = 0;
    end else if (m_gen_left > 0) begin
      m_mem[m_wr] = m_lfsr[1:0]; m_val[m_wr] = 1;
      m_wr++; m_gen_left--;
      if (m_gen_left == 0) begin m_gdone = 1; m_active = 1; m_armed = 0; end
    end else if (m_active) begin
      if (m_pend) begin
        if (bus.check_en) begin
          m_pend = 0;
          if (!m_check) begin m_fail = 1; m_active = 0; end
          else if (m_step == m_L - 1) begin m_done = 1; m_active = 0; end
          else begin m_step++; m_armed = 0; end
        end
      end else if (!m_armed) begin
        m_armed = (ks == 4'h0);
      end else if (bus.player_en && $countones(ks) == 1) begin
        m_ptile = 2'($clog2(ks));
        m_check = (m_ptile == m_mem[m_step]);
        m_pend  = 1;
      end
    end
    m_kq1 = m_kq0; m_kq0 = bus.keys;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  always @(negedge clock) begin
    if (!resetn) m_reset();
    cmp("gen_done", bus.gen_done, m_gdone);
    cmp("player_input", bus.player_input, m_pend);
    cmp("check", bus.check, m_check);
    cmp("pressed_tile", bus.pressed_tile, m_ptile);
    cmp("step", bus.step, 8'(m_step));
    cmp("round_done", bus.round_done, m_done);
    cmp("fail", bus.fail, m_fail);
    if (m_rd_val) cmp("rd_tile", bus.rd_tile, m_rd);
    if (resetn) m_advance();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start_round(input int l, input int exp_lat);
    int n;
    bus.keys = 4'hF; bus.gen_start = 1'b1; bus.len = 5'(l);
    tick();
    bus.gen_start = 1'b0;
    cmp("gs_clr_pinput", bus.player_input, 0);
    cmp("gs_clr_check", bus.check, 0);
    cmp("gs_clr_step", bus.step, 0);
    cmp("gs_clr_done", bus.round_done, 0);
    cmp("gs_clr_fail", bus.fail, 0);
    n = 0;
    while (!bus.gen_done && n < 40) begin tick(); n++; end
    cmp("gen_latency", 8'(n), 8'(exp_lat));
  endtask

  task automatic press(input logic [1:0] tile, output int n);
    bus.keys = ~(4'b0001 << tile); bus.player_en = 1'b1;
    n = 0;
    while (!bus.player_input && n < 12) begin tick(); n++; end
    if (!bus.player_input) cmp("press_timeout", bus.player_input, 1);
  endtask

  task automatic check_pulse(input bit release_keys);
    if (release_keys) bus.keys = 4'hF;
    bus.check_en = 1'b1;
    tick();
    bus.check_en = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    cmp({tag, "_gen_done"}, bus.gen_done, 0);
    cmp({tag, "_pinput"}, bus.player_input, 0);
    cmp({tag, "_check"}, bus.check, 0);
    cmp({tag, "_ptile"}, bus.pressed_tile, 0);
    cmp({tag, "_step"}, bus.step, 0);
    cmp({tag, "_done"}, bus.round_done, 0);
    cmp({tag, "_fail"}, bus.fail, 0);
    cmp({tag, "_rd_tile"}, bus.rd_tile, 0);
  endtask

  logic [1:0] lit [4];
  int n, hold_cnt;

  initial begin
    bus.gen_start = 0; bus.len = 0; bus.rd_index = 0; bus.player_en = 0;
    bus.keys = 4'hF; bus.check_en = 0;
    repeat (3) tick();
    all_zero("reset");
    cmp("pin_seed", m_lfsr, 8'hA5);

    // First round starts on the first live edge: tiles from A5->4A,95,2A,54.
    resetn = 1'b1; bus.gen_start = 1'b1; bus.len = 5'd4;
    tick();
    bus.gen_start = 1'b0;
    n = 0;
    while (!bus.gen_done && n < 40) begin tick(); n++; end
    cmp("gen_lat_len4", 8'(n), 4);
    lit[0] = 2'd2; lit[1] = 2'd1; lit[2] = 2'd2; lit[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cmp("pin_model_mem", m_mem[i], lit[i]);
      bus.rd_index = 4'(i);
      tick();
      cmp("rd_tile_lit", bus.rd_tile, lit[i]);
    end

    // Correct round of 3.
    start_round(3, 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      press(m_mem[i], n);
      cmp("press_lat", 8'(n), 3);
      cmp("good_check", bus.check, 1);
      check_pulse(1);
      cmp("pinput_clr", bus.player_input, 0);
      if (i < 2) begin cmp("step_adv", bus.step, 8'(i + 1)); tick(); end
      else begin cmp("round_done", bus.round_done, 1); cmp("step_last", bus.step, 2); end
    end

    // Wrong press at step 0.
    start_round(2, 2);
    tick();
    press(m_mem[0] ^ 2'd1, n);
    cmp("bad_check", bus.check, 0);
    check_pulse(1);
    cmp("fail_set", bus.fail, 1);
    cmp("fail_no_done", bus.round_done, 0);

    // Key held through check_en; player_en low blocks capture.
    start_round(3, 3);
    tick();
    press(m_mem[0], n);
    check_pulse(0);
    repeat (6) tick();
    cmp("held_no_recapture", bus.player_input, 0);
    cmp("held_step", bus.step, 1);
    bus.keys = 4'hF; bus.player_en = 1'b0;
    repeat (3) tick();
    bus.keys = ~(4'b0001 << m_mem[1]);
    repeat (6) tick();
    cmp("pen_blocks", bus.player_input, 0);
    press(m_mem[1], n);
    cmp("pen_lat", 8'(n), 1);

    // gen_start while in HOLD; len 0 acts as 1.
    start_round(0, 1);
    tick();
    bus.keys = 4'b1100; bus.player_en = 1'b1;
    repeat (6) tick();
    cmp("multi_ignored", bus.player_input, 0);
    press(2'd0, n);
    cmp("single_lat", 8'(n), 3);
    cmp("single_tile", bus.pressed_tile, 0);
    check_pulse(1);

    start_round(20, 16);

    // Restart mid-GEN.
    bus.gen_start = 1'b1; bus.len = 5'd8;
    tick();
    bus.gen_start = 1'b0;
    repeat (3) tick();
    start_round(5, 5);

    // Reset mid-GEN.
    bus.gen_start = 1'b1; bus.len = 5'd10;
    tick();
    bus.gen_start = 1'b0;
    repeat (3) tick();
    #2 resetn = 1'b0;
    #1 all_zero("midgen_reset");
    tick();
    resetn = 1'b1;

    // Random play against the model.
    hold_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.rd_index = 4'($urandom_range(0, 15));
      if (hold_cnt == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5:
            bus.keys = m_val[m_step] ? ~(4'b0001 << m_mem[m_step]) : 4'hF;
          6: bus.keys = ~(4'b0001 << $urandom_range(0, 3));
          7: bus.keys = 4'($urandom_range(0, 15));
          default: bus.keys = 4'hF;
        endcase
        hold_cnt = $urandom_range(1, 6);
      end else hold_cnt--;
      bus.player_en = ($urandom_range(0, 9) != 0);
      bus.check_en  = ($urandom_range(0, 3) == 0);
      bus.gen_start = (!m_active && m_gen_left == 0 && $urandom_range(0, 3) == 0) ||
                      ($urandom_range(0, 199) == 0);
      bus.len = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 20))
                                            : 5'($urandom_range(1, 4));
      tick();
    end
    bus.gen_start = 0; bus.check_en = 0; bus.keys = 4'hF;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
